// File: rtl/dff_shift_ctrl_if.sv
// Load-side handshake bundle for the serial chain controller.
// The requester drives the master modport; the controller consumes the slave modport.
interface dff_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             load_dir;
    logic             abort;

    modport master (
        output load_valid,
        output load_data,
        output load_dir,
        output abort,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dir,
        input  abort,
        output load_ready
    );
endinterface

// File: rtl/dff_shift_ctrl.sv
// Drives a WIDTH-long external flip-flop chain one bit per enabled clock and
// captures the bits falling out of its far end into rx_data.
module dff_shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dff_shift_ctrl_if.slave  ld,
    input  logic             ser_q,
    output logic             ser_data,
    output logic             ser_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] rx_data
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, ABORT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shadow;
    logic             dir_r;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ld.load_valid) state_next = SHIFT;
            SHIFT: begin
                if (ld.abort)          state_next = ABORT;
                else if (cnt == LAST)  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // LSB-first enters at the top and migrates down so the first bit lands in rx[0].
    always_comb begin
        rx_next = dir_r ? {ser_q, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], ser_q};
        bit_idx = dir_r ? cnt : LAST - cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            dir_r   <= 1'b0;
            cnt     <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld.load_valid) begin
                        shadow <= ld.load_data;
                        dir_r  <= ld.load_dir;
                        cnt    <= '0;
                        rx_sh  <= '0;
                    end
                end
                SHIFT: begin
                    if (!ld.abort) begin
                        rx_sh <= rx_next;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) rx_data <= rx_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld.load_ready = 1'b0;
        ser_en        = 1'b0;
        ser_data      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        aborted       = 1'b0;
        case (state)
            IDLE: begin
                ld.load_ready = 1'b1;
                busy          = 1'b0;
            end
            SHIFT: begin
                ser_en   = 1'b1;
                ser_data = shadow[bit_idx];
            end
            DONE:    done    = 1'b1;
            ABORT:   aborted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Directed bench: drives the controller against a modelled 8-FF chain.
module tb_dff_shift_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ser_q;
    logic             ser_data;
    logic             ser_en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH-1:0] rx_data;

    logic [7:0]       chain;
    logic [7:0]       chainInit;
    logic             chainLoad;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_shift_ctrl_if #(.WIDTH(WIDTH)) ld ();

    dff_shift_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .ser_q    (ser_q),
        .ser_data (ser_data),
        .ser_en   (ser_en),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .rx_data  (rx_data)
    );

    // External chain: first FF takes ser_data, last FF feeds ser_q.
    always @(posedge clk) begin
        if (chainLoad)   chain <= chainInit;
        else if (ser_en) chain <= {chain[6:0], ser_data};
    end
    assign ser_q = chain[7];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic dir, input logic abt);
        ld.load_valid = valid;
        ld.load_data  = data;
        ld.load_dir   = dir;
        ld.abort      = abt;
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] expRx);
        checkOutput({tag, "_ready"},   ld.load_ready, 1);
        checkOutput({tag, "_en"},      ser_en, 0);
        checkOutput({tag, "_sd"},      ser_data, 0);
        checkOutput({tag, "_busy"},    busy, 0);
        checkOutput({tag, "_done"},    done, 0);
        checkOutput({tag, "_aborted"}, aborted, 0);
        checkOutput({tag, "_rx"},      rx_data, expRx);
    endtask

    // Starts in the first SHIFT cycle, ends in the cycle after the eighth one.
    task automatic shiftCycles(input string tag, input logic [7:0] expSeq);
        for (int k = 0; k < 8; k++) begin
            checkOutput({tag, "_en"}, ser_en, 1);
            checkOutput({tag, "_sd"}, ser_data, expSeq[7-k]);
            checkOutput({tag, "_ready"}, ld.load_ready, 0);
            @(negedge clk);
        end
    endtask

    task automatic startShift(input logic [7:0] data, input logic dir, input logic [7:0] preload);
        applyStimulus(1'b1, data, dir, 1'b0);
        chainInit = preload;
        chainLoad = 1'b1;
        @(negedge clk);
        chainLoad = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic runShift(input string tag, input logic [7:0] data, input logic dir, input logic [7:0] preload,
                            input logic [7:0] expSeq, input logic [7:0] expRx, input logic [7:0] expChain);
        checkOutput({tag, "_ready0"}, ld.load_ready, 1);
        startShift(data, dir, preload);
        shiftCycles(tag, expSeq);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_dEn"}, ser_en, 0);
        checkOutput({tag, "_dBusy"}, busy, 1);
        checkOutput({tag, "_dReady"}, ld.load_ready, 0);
        checkOutput({tag, "_rx"}, rx_data, expRx);
        checkOutput({tag, "_chain"}, chain, expChain);
        @(negedge clk);
        checkIdle({tag, "_idle"}, expRx);
    endtask

    initial begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        chainLoad = 1'b0;
        chainInit = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkIdle("reset", 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        runShift("msbA5", 8'hA5, 1'b0, 8'h3C, 8'hA5, 8'h3C, 8'hA5);
        runShift("lsbA5", 8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5);
        runShift("msb1E", 8'h1E, 1'b0, 8'h0F, 8'h1E, 8'h0F, 8'h1E);
        runShift("lsb1E", 8'h1E, 1'b1, 8'h0F, 8'h78, 8'hF0, 8'h78);

        // Abort on the 4th shift cycle; abort stays high through ABORT and must be ignored there.
        startShift(8'h5A, 1'b0, 8'h33);
        checkOutput("ab4_sd0", ser_data, 0);
        repeat (3) @(negedge clk);
        checkOutput("ab4_sd3", ser_data, 1);
        checkOutput("ab4_en3", ser_en, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("ab4_aborted", aborted, 1);
        checkOutput("ab4_done", done, 0);
        checkOutput("ab4_en", ser_en, 0);
        checkOutput("ab4_busy", busy, 1);
        checkOutput("ab4_ready", ld.load_ready, 0);
        checkOutput("ab4_rx", rx_data, 8'hF0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkIdle("ab4_idle", 8'hF0);

        // Abort on the final shift cycle still pre-empts completion.
        startShift(8'hC3, 1'b0, 8'h96);
        repeat (7) @(negedge clk);
        checkOutput("ab8_en", ser_en, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ab8_aborted", aborted, 1);
        checkOutput("ab8_done", done, 0);
        checkOutput("ab8_rx", rx_data, 8'hF0);
        @(negedge clk);
        checkIdle("ab8_idle", 8'hF0);

        // load_valid held high: data changes mid-shift must not disturb the shadow word.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        chainInit = 8'h96;
        chainLoad = 1'b1;
        @(negedge clk);
        chainLoad = 1'b0;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        shiftCycles("b2b1", 8'h01);
        checkOutput("b2b1_done", done, 1);
        checkOutput("b2b1_ready", ld.load_ready, 0);
        checkOutput("b2b1_rx", rx_data, 8'h96);
        @(negedge clk);
        checkOutput("b2b_gapReady", ld.load_ready, 1);
        checkOutput("b2b_gapEn", ser_en, 0);
        checkOutput("b2b_gapDone", done, 0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        shiftCycles("b2b2", 8'hFF);
        checkOutput("b2b2_done", done, 1);
        checkOutput("b2b2_rx", rx_data, 8'h01);
        checkOutput("b2b2_chain", chain, 8'hFF);
        @(negedge clk);
        checkIdle("b2b_idle", 8'h01);

        // Reset mid-shift, with handshake and abort asserted alongside it.
        startShift(8'h77, 1'b0, 8'h55);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b1);
        @(negedge clk);
        checkIdle("rstMid", 8'h00);
        @(negedge clk);
        checkIdle("rstHold", 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        runShift("postRst", 8'h81, 1'b0, 8'hC5, 8'h81, 8'hC5, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dff_shift_ctrl.md
DFF_SHIFT_CTRL -- requirements
Module: dff_shift_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, number of flip-flops in the controlled serial chain (legal range 2..32).
REQ-002 The block SHALL have a single clock and a reset that is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 load_valid  input  1  requester offers a word to shift.
REQ-006 load_ready  output  1  controller can accept a word.
REQ-007 load_data  input  WIDTH  word to shift into the chain.
REQ-008 load_dir  input  1  bit order: 0 = MSB first, 1 = LSB first; sampled with load_data.
REQ-009 abort  input  1  terminate an in-progress shift.
REQ-010 ser_q  input  1  Q of the last flip-flop in the chain.
REQ-011 ser_data  output  1  D input of the first flip-flop in the chain.
REQ-012 ser_en  output  1  clock enable of the chain; the chain shifts on each rising edge where ser_en=1.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 aborted  output  1  one-cycle pulse on abort completion.
REQ-016 rx_data  output  WIDTH  bits captured from ser_q during the last completed shift.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, DONE and ABORT.
REQ-018 IDLE: load_ready=1, ser_en=0, busy=0; a handshake (load_valid=1 with load_ready=1 at an edge) SHALL latch load_data/load_dir into a shadow register, clear the bit counter and the rx shift register, and enter SHIFT.
REQ-019 SHIFT: load_ready=0, busy=1, ser_en=1 every cycle; ser_data SHALL be bit k of the shadow word on the k-th shift cycle (k=0..WIDTH-1), i.e. shadow[WIDTH-1-k] if MSB first, shadow[k] if LSB first.
REQ-020 On each SHIFT-cycle edge, ser_q SHALL be captured so that after WIDTH edges rx_data holds the captured bits in the same order convention (first captured bit in rx_data[WIDTH-1] for MSB first, in rx_data[0] for LSB first).
REQ-021 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE; with a handshake at edge T, ser_en is high during cycles T+1..T+WIDTH and done is high during cycle T+WIDTH+1.
REQ-022 DONE: done=1, ser_en=0, load_ready=0, busy=1, for exactly one cycle, then IDLE.
REQ-023 rx_data SHALL update only on entry to DONE and hold its value until the next DONE or reset.
REQ-024 abort=1 at any SHIFT-cycle edge, including the last, SHALL enter ABORT; that edge SHALL NOT shift the chain for completion purposes, done SHALL NOT pulse, and rx_data SHALL keep its previous value.
REQ-025 ABORT: aborted=1, ser_en=0, load_ready=0, busy=1, for exactly one cycle, then IDLE.
REQ-026 abort SHALL be ignored in IDLE, DONE and ABORT.
REQ-027 load_valid SHALL be ignored whenever load_ready=0; no request is queued.
REQ-028 The controller SHALL accept back-to-back words with exactly one non-ready cycle (DONE or ABORT) between shifts.
REQ-029 load_data, load_dir and ser_q SHALL be treated as don't-care outside their sampling edges; the shadow register is immune to input changes during SHIFT.

Reset
REQ-030 With rst_n=0 at an edge, the FSM SHALL enter IDLE, and the shadow register, counter and rx_data SHALL clear to 0.
REQ-031 After reset: load_ready=1, ser_en=0, ser_data=0, busy=0, done=0, aborted=0, rx_data=0.
REQ-032 A reset during SHIFT, DONE or ABORT SHALL abandon the operation with no done or aborted pulse; reset SHALL take priority over handshake and abort at the same edge.

Verification
REQ-033 WIDTH=8, load 0xA5 MSB first, ser_q looped from an 8-FF chain preloaded with 0x3C -> ser_data sequence 1,0,1,0,0,1,0,1; ser_en high for 8 cycles; done pulses at T+9; rx_data=0x3C; chain holds 0xA5.
REQ-034 Same stimulus with load_dir=1 -> ser_data 1,0,1,0,0,1,0,1 (LSB first of 0xA5); the bit order in rx_data follows REQ-020.
REQ-035 Abort asserted on the 4th SHIFT cycle -> aborted pulses one cycle later, no done, rx_data unchanged from the previous result, load_ready=1 the following cycle.
REQ-036 load_valid held high continuously with 0x01 then 0xFF -> two shifts separated by exactly one DONE cycle; load_valid during SHIFT is ignored.
REQ-037 rst_n=0 in the middle of a shift -> next cycle all outputs at reset values, no pulses; a new load is accepted immediately after release.
